// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: frames raw scan bytes and folds E0/F0 prefixes into key events.
// Latency: changed/key_valid pulse 1 clk after the stop-bit fall is seen (~3 clk after the pin edge).
// Backpressure: none; the keyboard is clock master, so outputs are pulses the core must catch.
module ps2_rx #(
    parameter bit          CHECK_PARITY = 1'b0,
    parameter logic [15:0] TIMEOUT      = 16'd2000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_clk,
    input  logic       key_data,
    output logic [7:0] data,
    output logic       changed,
    output logic [7:0] key_code,
    output logic       key_released,
    output logic       key_extended,
    output logic       key_valid,
    output logic       frame_error
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BITS   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    localparam logic [7:0] PFX_EXT = 8'hE0;
    localparam logic [7:0] PFX_REL = 8'hF0;

    logic       kc_s1_q, kc_s2_q, kc_prev_q;
    logic       kd_s1_q, kd_s2_q;
    logic       fall;

    logic [1:0]  state_q,    state_d;
    logic [2:0]  bitcnt_q,   bitcnt_d;
    logic [7:0]  shift_q,    shift_d;
    logic        par_q,      par_d;
    logic [15:0] tmo_q,      tmo_d;
    logic [7:0]  data_q,     data_d;
    logic        changed_q,  changed_d;
    logic [7:0]  code_q,     code_d;
    logic        rel_q,      rel_d;
    logic        ext_q,      ext_d;
    logic        kv_q,       kv_d;
    logic        fe_q,       fe_d;
    logic        ext_pend_q, ext_pend_d;
    logic        rel_pend_q, rel_pend_d;
    logic        parity_ok;

    // Two-flop synchronizers plus the previous synced clock, idling high like the bus
    always_ff @(posedge clk) begin
        if (reset) begin
            kc_s1_q   <= 1'b1;
            kc_s2_q   <= 1'b1;
            kc_prev_q <= 1'b1;
            kd_s1_q   <= 1'b1;
            kd_s2_q   <= 1'b1;
        end else begin
            kc_s1_q   <= key_clk;
            kc_s2_q   <= kc_s1_q;
            kc_prev_q <= kc_s2_q;
            kd_s1_q   <= key_data;
            kd_s2_q   <= kd_s1_q;
        end
    end

    // Comparing against the registered copy catches even a single-cycle low phase
    assign fall      = kc_prev_q & ~kc_s2_q;
    assign parity_ok = (CHECK_PARITY == 1'b0) || (^{shift_q, par_q});

    // Frame FSM, timeout and prefix-folding event layer
    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        tmo_d      = tmo_q;
        data_d     = data_q;
        changed_d  = 1'b0;
        code_d     = code_q;
        rel_d      = rel_q;
        ext_d      = ext_q;
        kv_d       = 1'b0;
        fe_d       = 1'b0;
        ext_pend_d = ext_pend_q;
        rel_pend_d = rel_pend_q;

        if (state_q == S_IDLE) begin
            tmo_d = 16'd0;
            if (fall) begin
                if (!kd_s2_q) begin
                    state_d  = S_BITS;
                    bitcnt_d = 3'd0;
                end else begin
                    fe_d = 1'b1;
                end
            end
        end else if (fall) begin
            tmo_d = 16'd0;
            case (state_q)
                S_BITS: begin
                    shift_d  = {kd_s2_q, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
                S_PARITY: begin
                    par_d   = kd_s2_q;
                    state_d = S_STOP;
                end
                default: begin
                    state_d = S_IDLE;
                    if (kd_s2_q && parity_ok) begin
                        data_d    = shift_q;
                        changed_d = 1'b1;
                        if (shift_q == PFX_EXT) begin
                            ext_pend_d = 1'b1;
                        end else if (shift_q == PFX_REL) begin
                            rel_pend_d = 1'b1;
                        end else begin
                            code_d     = shift_q;
                            rel_d      = rel_pend_q;
                            ext_d      = ext_pend_q;
                            kv_d       = 1'b1;
                            ext_pend_d = 1'b0;
                            rel_pend_d = 1'b0;
                        end
                    end else begin
                        fe_d = 1'b1;
                    end
                end
            endcase
        end else if (tmo_q >= TIMEOUT) begin
            // Keyboard went quiet mid-frame; pending prefixes survive the drop
            state_d = S_IDLE;
            tmo_d   = 16'd0;
            fe_d    = 1'b1;
        end else begin
            tmo_d = tmo_q + 16'd1;
        end
    end

    // State and output registers; reset wins over any in-flight frame
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            bitcnt_q   <= 3'd0;
            shift_q    <= 8'd0;
            par_q      <= 1'b0;
            tmo_q      <= 16'd0;
            data_q     <= 8'd0;
            changed_q  <= 1'b0;
            code_q     <= 8'd0;
            rel_q      <= 1'b0;
            ext_q      <= 1'b0;
            kv_q       <= 1'b0;
            fe_q       <= 1'b0;
            ext_pend_q <= 1'b0;
            rel_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tmo_q      <= tmo_d;
            data_q     <= data_d;
            changed_q  <= changed_d;
            code_q     <= code_d;
            rel_q      <= rel_d;
            ext_q      <= ext_d;
            kv_q       <= kv_d;
            fe_q       <= fe_d;
            ext_pend_q <= ext_pend_d;
            rel_pend_q <= rel_pend_d;
        end
    end

    assign data         = data_q;
    assign changed      = changed_q;
    assign key_code     = code_q;
    assign key_released = rel_q;
    assign key_extended = ext_q;
    assign key_valid    = kv_q;
    assign frame_error  = fe_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: one instance ignoring parity, one checking it.
// Frames are bit-banged on the pins; pulse outputs are counted by a negedge monitor.
// Pins of the unselected instance idle high.
module tb_ps2_rx;

    logic       clk;
    logic       reset;
    logic       kc, kd, sel;
    logic       kc0, kd0, kc1, kd1;

    logic [7:0] data0, code0, data1, code1;
    logic       changed0, rel0, ext0, kv0, fe0;
    logic       changed1, rel1, ext1, kv1, fe1;

    int n_cmp, n_err;
    int chg0_n, kv0_n, fe0_n, chg1_n, kv1_n, fe1_n, orphan_n;

    assign kc0 = sel ? 1'b1 : kc;
    assign kd0 = sel ? 1'b1 : kd;
    assign kc1 = sel ? kc : 1'b1;
    assign kd1 = sel ? kd : 1'b1;

    ps2_rx #(.CHECK_PARITY(1'b0), .TIMEOUT(16'd2000)) dut0 (
        .clk(clk), .reset(reset), .key_clk(kc0), .key_data(kd0),
        .data(data0), .changed(changed0), .key_code(code0),
        .key_released(rel0), .key_extended(ext0), .key_valid(kv0),
        .frame_error(fe0)
    );

    ps2_rx #(.CHECK_PARITY(1'b1), .TIMEOUT(16'd2000)) dut1 (
        .clk(clk), .reset(reset), .key_clk(kc1), .key_data(kd1),
        .data(data1), .changed(changed1), .key_code(code1),
        .key_released(rel1), .key_extended(ext1), .key_valid(kv1),
        .frame_error(fe1)
    );

    initial clk = 1'b0;
    always #7 clk = ~clk;

    // Count pulse-cycles away from the active edge
    always @(negedge clk) begin
        if (changed0) chg0_n++;
        if (kv0)      kv0_n++;
        if (fe0)      fe0_n++;
        if (changed1) chg1_n++;
        if (kv1)      kv1_n++;
        if (fe1)      fe1_n++;
        if ((kv0 && !changed0) || (kv1 && !changed1)) orphan_n++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Emit the first nbits bits of {stop, parity, byte, start}, LSB first
    task automatic send_frame(input logic st, input logic [7:0] b, input logic par,
                              input logic sp, input int nbits, input int low, input bit lat);
        logic [10:0] f;
        f = {sp, par, b, st};
        for (int i = 0; i < nbits; i++) begin
            kd = f[i];
            @(negedge clk);
            kc = 1'b0;
            if (lat && i == 10) begin
                @(negedge clk);
                @(negedge clk);
                chk("lat_early", {31'd0, changed0}, 32'd0);
                @(negedge clk);
                chk("lat_pulse", {31'd0, changed0}, 32'd1);
            end else begin
                repeat (low) @(negedge clk);
            end
            kc = 1'b1;
            repeat (2) @(negedge clk);
        end
        kd = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic good(input logic [7:0] b, input logic par);
        send_frame(1'b0, b, par, 1'b1, 11, 2, 1'b0);
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        chg0_n = 0; kv0_n = 0; fe0_n = 0; chg1_n = 0; kv1_n = 0; fe1_n = 0; orphan_n = 0;
        kc = 1'b1; kd = 1'b1; sel = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_data",  {24'd0, data0}, 32'h00);
        chk("rst_code",  {24'd0, code0}, 32'h00);
        chk("rst_flags", {27'd0, changed0, rel0, ext0, kv0, fe0}, 32'h0);

        // Plain make code with latency check
        send_frame(1'b0, 8'h14, 1'b1, 1'b1, 11, 2, 1'b1);
        chk("b14_data", {24'd0, data0}, 32'h14);
        chk("b14_chg",  chg0_n, 1);
        chk("b14_kv",   kv0_n, 1);
        chk("b14_code", {24'd0, code0}, 32'h14);
        chk("b14_re",   {30'd0, rel0, ext0}, 32'h0);

        // Break code F0 14
        good(8'hF0, 1'b1);
        chk("f0_data", {24'd0, data0}, 32'hF0);
        chk("f0_kv",   kv0_n, 1);
        good(8'h14, 1'b1);
        chk("brk_chg",  chg0_n, 3);
        chk("brk_kv",   kv0_n, 2);
        chk("brk_code", {24'd0, code0}, 32'h14);
        chk("brk_re",   {30'd0, rel0, ext0}, 32'h2);

        // Extended break E0 F0 75, then plain 75 with one-cycle clock lows
        good(8'hE0, 1'b0);
        good(8'hF0, 1'b1);
        good(8'h75, 1'b0);
        chk("ext_chg",  chg0_n, 6);
        chk("ext_kv",   kv0_n, 3);
        chk("ext_code", {24'd0, code0}, 32'h75);
        chk("ext_re",   {30'd0, rel0, ext0}, 32'h3);
        send_frame(1'b0, 8'h75, 1'b0, 1'b1, 11, 1, 1'b0);
        chk("mk75_kv", kv0_n, 4);
        chk("mk75_re", {30'd0, rel0, ext0}, 32'h0);

        // Bad start bit, then bad stop bit
        send_frame(1'b1, 8'h00, 1'b0, 1'b1, 1, 2, 1'b0);
        chk("badst_fe", fe0_n, 1);
        send_frame(1'b0, 8'h33, 1'b1, 1'b0, 11, 2, 1'b0);
        chk("badsp_fe",   fe0_n, 2);
        chk("badsp_chg",  chg0_n, 7);
        chk("badsp_data", {24'd0, data0}, 32'h75);

        // Timeout with a pending F0 that must survive the dropped frame
        good(8'hF0, 1'b1);
        send_frame(1'b0, 8'h29, 1'b1, 1'b1, 4, 2, 1'b0);
        repeat (100) @(negedge clk);
        chk("tmo_early", fe0_n, 2);
        repeat (1905) @(negedge clk);
        chk("tmo_fe",   fe0_n, 3);
        chk("tmo_data", {24'd0, data0}, 32'hF0);
        good(8'h29, 1'b1);
        chk("tmo_chg",  chg0_n, 9);
        chk("tmo_kv",   kv0_n, 5);
        chk("tmo_code", {24'd0, code0}, 32'h29);
        chk("tmo_re",   {30'd0, rel0, ext0}, 32'h2);

        // Parity-checking instance: good, bad parity, then good again
        sel = 1'b1;
        good(8'h14, 1'b1);
        chk("p_ok_data", {24'd0, data1}, 32'h14);
        chk("p_ok_chg",  chg1_n, 1);
        good(8'h14, 1'b0);
        chk("p_bad_fe",   fe1_n, 1);
        chk("p_bad_chg",  chg1_n, 1);
        chk("p_bad_data", {24'd0, data1}, 32'h14);
        good(8'h1C, 1'b0);
        chk("p_1c_data", {24'd0, data1}, 32'h1C);
        chk("p_1c_kv",   kv1_n, 2);
        chk("p_1c_code", {24'd0, code1}, 32'h1C);
        chk("p0_quiet",  chg0_n, 9);
        sel = 1'b0;

        // Reset mid-frame with a pending E0
        good(8'hE0, 1'b0);
        chk("rstm_pre", chg0_n, 10);
        send_frame(1'b0, 8'h5A, 1'b0, 1'b1, 6, 2, 1'b0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rstm_data", {24'd0, data0}, 32'h00);
        chk("rstm_code", {24'd0, code0}, 32'h00);
        chk("rstm_chg",  chg0_n, 10);
        chk("rstm_fe",   fe0_n, 3);
        good(8'h5A, 1'b1);
        chk("rstm_5a",   {24'd0, data0}, 32'h5A);
        chk("rstm_kv",   kv0_n, 6);
        chk("rstm_re",   {30'd0, rel0, ext0}, 32'h0);
        chk("rstm_fe2",  fe0_n, 3);
        chk("orphan_kv", orphan_n, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
